// File: rtl/bruin_physics_if.sv
// bruin_physics_if: game-control inputs and sprite-motion outputs of the player physics block
interface bruin_physics_if #(
  parameter int Y_W = 9,
  parameter int V_W = 8
);
  logic                  i_frame_tick;
  logic                  i_flap;
  logic                  i_game_start;
  logic                  i_lose;
  logic                  i_restart;
  logic [Y_W-1:0]        o_x;
  logic [Y_W-1:0]        o_y;
  logic signed [V_W-1:0] o_vel;
  logic [1:0]            o_state;
  logic                  o_flapped;
  logic                  o_game_over;
  modport master (
    output i_frame_tick, i_flap, i_game_start, i_lose, i_restart,
    input  o_x, o_y, o_vel, o_state, o_flapped, o_game_over
  );
  modport slave (
    input  i_frame_tick, i_flap, i_game_start, i_lose, i_restart,
    output o_x, o_y, o_vel, o_state, o_flapped, o_game_over
  );
endinterface

// File: rtl/bruin_physics.sv
// bruin_physics: fixed-point player height integration with gravity, flap impulse, ceiling clamp and floor death
module bruin_physics #(
  parameter int Y_W      = 9,
  parameter int FRAC     = 4,
  parameter int V_W      = 8,
  parameter int X_POS    = 200,
  parameter int Y_INIT   = 240,
  parameter int Y_MIN    = 10,
  parameter int Y_MAX    = 470,
  parameter int GRAVITY  = 4,
  parameter int FLAP_VEL = 48,
  parameter int VMAX     = 96,
  parameter int COOLDOWN = 6
) (
  input logic clk_100MHz,
  input logic rst_n,
  bruin_physics_if.slave bus
);
  localparam int PW = Y_W + FRAC;
  localparam int SW = PW + 2;
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [PW-1:0] L_INIT = PW'(Y_INIT << FRAC);
  localparam logic [PW-1:0] L_TOP_U = PW'(Y_MIN << FRAC);
  localparam logic [PW-1:0] L_BOT_U = PW'(Y_MAX << FRAC);
  localparam logic signed [SW-1:0] L_TOP = SW'(Y_MIN << FRAC);
  localparam logic signed [SW-1:0] L_BOT = SW'(Y_MAX << FRAC);
  localparam logic signed [V_W:0] L_VMAX = (V_W+1)'(VMAX);
  localparam logic signed [V_W:0] L_GRAV = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W-1:0] L_FLAP = V_W'(-FLAP_VEL);
  typedef enum logic [1:0] {IDLE, PLAY, DYING, OVER} state_t;
  state_t                r_state, w_state_n;
  logic [PW-1:0]         r_pos, w_pos_phys;
  logic signed [V_W-1:0] r_vel, w_vel_n, w_vel_phys;
  logic [CW-1:0]         r_cd, w_cd_n;
  logic                  r_pend, r_flapped;
  logic [2:0]            r_sync;
  logic                  w_rise, w_run, w_do_flap, w_ceil, w_floor, w_restart;
  logic signed [V_W:0]   w_vg;
  logic signed [SW-1:0]  w_pos_n;
  // One frame of physics: flap or gravity, integrate, then clamp at ceiling/floor
  always_comb begin
    w_rise     = r_sync[1] & ~r_sync[2];
    w_run      = bus.i_frame_tick && (r_state == PLAY || r_state == DYING);
    w_do_flap  = w_run && r_state == PLAY && !bus.i_lose && r_pend && r_cd == '0;
    w_vg       = $signed({r_vel[V_W-1], r_vel}) + L_GRAV;
    w_vel_n    = w_do_flap ? L_FLAP : (w_vg > L_VMAX) ? V_W'(VMAX) : w_vg[V_W-1:0];
    w_cd_n     = w_do_flap ? CW'(COOLDOWN) : (r_cd != '0) ? r_cd - CW'(1) : r_cd;
    w_pos_n    = $signed({2'b00, r_pos}) + SW'(w_vel_n);
    w_ceil     = w_pos_n <= L_TOP;
    w_floor    = w_pos_n >= L_BOT;
    w_pos_phys = w_ceil ? L_TOP_U : w_floor ? L_BOT_U : w_pos_n[PW-1:0];
    w_vel_phys = (w_ceil || w_floor) ? '0 : w_vel_n;
    w_restart  = r_state == OVER && bus.i_restart;
  end
  // Game phase sequencing; a floor hit outranks a same-cycle lose
  always_comb begin
    w_state_n = (r_state == IDLE && bus.i_game_start) ? PLAY :
                (w_run && w_floor)                    ? OVER :
                (r_state == PLAY && bus.i_lose)       ? DYING :
                w_restart                             ? IDLE : r_state;
  end
  // Phase register
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_n;
  end
  // Flap synchroniser/capture and motion state; restart reloads the power-on values
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_pend    <= 1'b0;
      r_flapped <= 1'b0;
      r_pos     <= L_INIT;
      r_vel     <= '0;
      r_cd      <= '0;
    end else begin
      r_sync    <= {r_sync[1:0], bus.i_flap};
      r_pend    <= r_state == PLAY && w_state_n == PLAY && !bus.i_frame_tick && (r_pend || w_rise);
      r_flapped <= w_do_flap;
      if (w_restart) begin
        r_pos <= L_INIT;
        r_vel <= '0;
        r_cd  <= '0;
      end else if (w_run) begin
        r_pos <= w_pos_phys;
        r_vel <= w_vel_phys;
        r_cd  <= w_cd_n;
      end
    end
  end
  assign bus.o_x         = Y_W'(X_POS);
  assign bus.o_y         = r_pos[PW-1:FRAC];
  assign bus.o_vel       = r_vel;
  assign bus.o_state     = r_state;
  assign bus.o_flapped   = r_flapped;
  assign bus.o_game_over = r_state == OVER;
endmodule

// File: tb/tb_bruin_physics.sv
// tb_bruin_physics: table vectors, hand sequences and random play checked against a frame-level model
module tb_bruin_physics;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nerr = 0;
  int nchk = 0;
  int m_pos, m_vel, m_cd, m_st;
  bit m_pend, m_fl;
  bruin_physics_if #(.Y_W(9), .V_W(8)) a();
  bruin_physics_if #(.Y_W(9), .V_W(8)) b();
  bruin_physics u_a (.clk_100MHz(clk), .rst_n(rst_n), .bus(a.slave));
  bruin_physics #(.Y_INIT(12)) u_b (.clk_100MHz(clk), .rst_n(rst_n), .bus(b.slave));
  always #5 clk = ~clk;
  typedef struct {bit fl; bit lo; int vel; int y; int st; bit fp;} vec_t;
  vec_t tbl[8];
  task automatic chk(string n, int act, int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic check_model(string tag);
    chk({tag, "_y"}, int'(a.o_y), m_pos / 16);
    chk({tag, "_vel"}, int'($signed(a.o_vel)), m_vel);
    chk({tag, "_state"}, int'(a.o_state), m_st);
    chk({tag, "_flapped"}, int'(a.o_flapped), int'(m_fl));
    chk({tag, "_go"}, int'(a.o_game_over), int'(m_st == 3));
  endtask
  task automatic model_reset();
    m_pos = 240 * 16; m_vel = 0; m_cd = 0; m_st = 0; m_pend = 0; m_fl = 0;
  endtask
  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask
  task automatic tick(bit l);
    @(negedge clk); a.i_frame_tick = 1'b1; a.i_lose = l;
    @(negedge clk); a.i_frame_tick = 1'b0; a.i_lose = 1'b0;
    if (m_st == 1 && l) begin m_st = 2; m_pend = 0; end
    m_fl = 0;
    if (m_st == 1 || m_st == 2) begin
      if (m_st == 1 && m_pend && m_cd == 0) begin
        m_vel = -48; m_cd = 6; m_fl = 1;
      end else begin
        m_vel = (m_vel + 4 > 96) ? 96 : m_vel + 4;
        if (m_cd > 0) m_cd--;
      end
      m_pos += m_vel;
      if (m_pos <= 160) begin m_pos = 160; m_vel = 0; end
      else if (m_pos >= 7520) begin m_pos = 7520; m_vel = 0; m_st = 3; end
    end
    m_pend = 0;
    check_model("tick");
  endtask
  task automatic flap_press();
    @(negedge clk); a.i_flap = 1'b1;
    repeat (2) @(negedge clk);
    a.i_flap = 1'b0;
    repeat (4) @(negedge clk);
    if (m_st == 1) m_pend = 1;
    m_fl = 0;
  endtask
  task automatic pulse_lose();
    @(negedge clk); a.i_lose = 1'b1;
    @(negedge clk); a.i_lose = 1'b0;
    if (m_st == 1) begin m_st = 2; m_pend = 0; end
    m_fl = 0;
    chk("lose_state", int'(a.o_state), m_st);
  endtask
  task automatic pulse_start();
    @(negedge clk); a.i_game_start = 1'b1;
    @(negedge clk); a.i_game_start = 1'b0;
    if (m_st == 0) m_st = 1;
    m_fl = 0;
    chk("start_state", int'(a.o_state), m_st);
  endtask
  task automatic pulse_restart();
    @(negedge clk); a.i_restart = 1'b1;
    @(negedge clk); a.i_restart = 1'b0;
    if (m_st == 3) model_reset();
    m_fl = 0;
    check_model("restart");
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end
  initial begin
    int mx;
    bit seen;
    {a.i_frame_tick, a.i_flap, a.i_game_start, a.i_lose, a.i_restart} = '0;
    {b.i_frame_tick, b.i_flap, b.i_game_start, b.i_lose, b.i_restart} = '0;
    tbl[0] = '{0, 0,   4, 240, 1, 0};
    tbl[1] = '{0, 0,   8, 240, 1, 0};
    tbl[2] = '{0, 0,  12, 241, 1, 0};
    tbl[3] = '{0, 0,  16, 242, 1, 0};
    tbl[4] = '{1, 0, -48, 239, 1, 1};
    tbl[5] = '{0, 0, -44, 236, 1, 0};
    tbl[6] = '{1, 1, -40, 234, 2, 0};
    tbl[7] = '{0, 0, -36, 232, 2, 0};
    do_reset();
    check_model("reset");
    chk("reset_x", int'(a.o_x), 200);
    tick(0);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].fl) flap_press();
      tick(tbl[i].lo);
      chk($sformatf("tbl%0d_vel", i), int'($signed(a.o_vel)), tbl[i].vel);
      chk($sformatf("tbl%0d_y", i), int'(a.o_y), tbl[i].y);
      chk($sformatf("tbl%0d_state", i), int'(a.o_state), tbl[i].st);
      chk($sformatf("tbl%0d_flapped", i), int'(a.o_flapped), int'(tbl[i].fp));
    end
    do_reset();
    pulse_start();
    flap_press();
    tick(0);
    chk("t2_vel", int'($signed(a.o_vel)), -48);
    chk("t2_y", int'(a.o_y), 237);
    chk("t2_flapped", int'(a.o_flapped), 1);
    @(negedge clk);
    chk("t2_flapped_drop", int'(a.o_flapped), 0);
    tick(0);
    chk("t2_vel2", int'($signed(a.o_vel)), -44);
    tick(0);
    flap_press();
    tick(0);
    chk("t3_dropped_vel", int'($signed(a.o_vel)), -36);
    chk("t3_dropped_fl", int'(a.o_flapped), 0);
    repeat (3) tick(0);
    chk("t3_cd_vel", int'($signed(a.o_vel)), -24);
    flap_press();
    tick(0);
    chk("t3_accept_vel", int'($signed(a.o_vel)), -48);
    chk("t3_accept_fl", int'(a.o_flapped), 1);
    @(negedge clk); b.i_game_start = 1'b1;
    @(negedge clk); b.i_game_start = 1'b0; b.i_flap = 1'b1;
    repeat (2) @(negedge clk);
    b.i_flap = 1'b0;
    repeat (4) @(negedge clk);
    b.i_frame_tick = 1'b1;
    @(negedge clk); b.i_frame_tick = 1'b0;
    chk("t4_y", int'(b.o_y), 10);
    chk("t4_vel", int'($signed(b.o_vel)), 0);
    chk("t4_state", int'(b.o_state), 1);
    chk("t4_go", int'(b.o_game_over), 0);
    do_reset();
    pulse_start();
    mx = 0;
    for (int i = 0; i < 100 && !a.o_game_over; i++) begin
      tick(0);
      if (int'($signed(a.o_vel)) > mx) mx = int'($signed(a.o_vel));
    end
    chk("t5_vmax", mx, 96);
    chk("t5_y", int'(a.o_y), 470);
    chk("t5_state", int'(a.o_state), 3);
    chk("t5_go", int'(a.o_game_over), 1);
    flap_press();
    pulse_lose();
    repeat (2) tick(0);
    chk("t5_y_hold", int'(a.o_y), 470);
    pulse_restart();
    chk("t5_restart_y", int'(a.o_y), 240);
    chk("t5_restart_state", int'(a.o_state), 0);
    pulse_start();
    for (int i = 0; i < 40 && a.o_y < 9'd300; i++) tick(0);
    chk("t6_reach300", int'(a.o_y >= 9'd300), 1);
    pulse_lose();
    chk("t6_dying", int'(a.o_state), 2);
    flap_press();
    seen = 0;
    for (int i = 0; i < 100 && !a.o_game_over; i++) begin
      tick(0);
      if (a.o_flapped) seen = 1;
    end
    chk("t6_no_flap", int'(seen), 0);
    chk("t6_y", int'(a.o_y), 470);
    chk("t6_state", int'(a.o_state), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_y", int'(a.o_y), 240);
    chk("t6_rst_state", int'(a.o_state), 0);
    chk("t6_rst_go", int'(a.o_game_over), 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    pulse_start();
    for (int s = 0; s < 400; s++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 25) flap_press();
      else if (r < 27) pulse_lose();
      else if (r < 31) pulse_start();
      else if (r < 35) pulse_restart();
      else tick($urandom_range(0, 49) == 0);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
